// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request and response handshake.
// Latency: response valid WAIT_STATES+1 cycles after the request is accepted.
// Backpressure: rsp_* held stable until rsp_ready; one request at a time, req_ready only when idle.
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        write_q, write_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // Transaction view: live inputs while idle (a zero-wait-state request enters
  // RESP on its own acceptance edge), captured copy afterwards.
  logic          t_write;
  logic [31:0]   t_addr;
  logic [31:0]   t_wdata;
  logic [3:0]    t_be;
  logic          t_err;
  logic [AW-1:0] t_idx;
  logic          enter_resp;
  logic          mem_we;

  // Select the transaction fields and decode alignment / range error
  always_comb begin
    if (state_q == IDLE) begin
      t_write = req_write;
      t_addr  = req_addr;
      t_wdata = req_wdata;
      t_be    = req_be;
    end else begin
      t_write = write_q;
      t_addr  = addr_q;
      t_wdata = wdata_q;
      t_be    = be_q;
    end
    t_err = (t_addr[1:0] != 2'b00) || (|t_addr[31:AW+2]);
    t_idx = t_addr[AW+1:2];
  end

  // Next-state, capture and response-data logic
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    write_d   = write_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    req_ready = 1'b0;

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          if (WAIT_STATES > 0) begin
            state_d = WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Response contents and the store itself are fixed on the RESP entry edge;
    // a reset before that edge leaves memory untouched.
    enter_resp = (state_d == RESP) && (state_q != RESP);
    if (enter_resp) begin
      err_d   = t_err;
      rdata_d = (!t_write && !t_err) ? mem[t_idx] : 32'd0;
    end
    mem_we = enter_resp && t_write && !t_err && reset;
  end

  // State and captured-request registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      write_q <= 1'b0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      be_q    <= 4'd0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Byte-enabled store; storage is deliberately not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (t_be[b]) begin
          mem[t_idx][8*b +: 8] <= t_wdata[8*b +: 8];
        end
      end
    end
  end

  // Outputs are gated by state so reset clears them immediately
  always_comb begin
    rsp_valid = (state_q == RESP);
    rsp_err   = rsp_valid & err_q;
    rsp_rdata = rsp_valid ? rdata_q : 32'd0;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: a WAIT_STATES=2 instance and a WAIT_STATES=0 instance.
// Expected response pushed when a request is driven, popped when the response handshakes.
// Covers latency, byte enables, errors, backpressure stability and reset abort.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_ready = 1'b0;

  logic        valid_a, valid_b;
  logic        rr_a, rr_b, rv_a, rv_b, re_a, re_b;
  logic [31:0] rd_a, rd_b;
  logic        o_req_ready, o_rsp_valid, o_rsp_err;
  logic [31:0] o_rsp_rdata;

  always #5 clk = ~clk;

  assign valid_a     = req_valid & ~sel;
  assign valid_b     = req_valid & sel;
  assign o_req_ready = sel ? rr_b : rr_a;
  assign o_rsp_valid = sel ? rv_b : rv_a;
  assign o_rsp_err   = sel ? re_b : re_a;
  assign o_rsp_rdata = sel ? rd_b : rd_a;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(valid_a), .req_ready(rr_a), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv_a), .rsp_ready(rsp_ready), .rsp_rdata(rd_a), .rsp_err(re_a)
  );

  mem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset),
    .req_valid(valid_b), .req_ready(rr_b), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rv_b), .rsp_ready(rsp_ready), .rsp_rdata(rd_b), .rsp_err(re_b)
  );

  int n_run = 0;
  int n_fail = 0;
  logic [32:0] sb [$];
  logic [31:0] mdl  [256];
  logic [31:0] mdl0 [16];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int stall);
    int depth, exp_lat, lat, idx, bound;
    logic err;
    logic [31:0] exp_rd, w, snap_rd;
    logic snap_err;
    logic [32:0] e;
    depth   = sel ? 16 : 256;
    exp_lat = sel ? 1 : 3;
    err     = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(depth));
    exp_rd  = 32'd0;
    if (!err) begin
      idx = int'(addr[13:2]);
      w = sel ? mdl0[idx] : mdl[idx];
      if (wr) begin
        for (int b = 0; b < 4; b++) if (be[b]) w[8*b +: 8] = wdata[8*b +: 8];
        if (sel) mdl0[idx] = w; else mdl[idx] = w;
      end else begin
        exp_rd = w;
      end
    end
    sb.push_back({err, exp_rd});

    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = 1'b0;
    bound = 20;
    while (!o_req_ready && bound > 0) begin
      @(negedge clk);
      bound--;
    end
    chk("accept_ready", o_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    // Garbage on the request bus must not disturb the transaction in flight
    req_write = ~wr; req_addr = $urandom; req_wdata = $urandom; req_be = 4'($urandom);
    lat = 1;
    while (!o_rsp_valid && lat < 20) begin
      chk("wait_rdata", o_rsp_rdata, 0);
      chk("wait_err", o_rsp_err, 0);
      chk("wait_req_ready", o_req_ready, 0);
      @(negedge clk);
      lat++;
    end
    chk("latency", lat, exp_lat);
    snap_rd = o_rsp_rdata;
    snap_err = o_rsp_err;
    for (int s = 0; s < stall; s++) begin
      chk("stall_req_ready", o_req_ready, 0);
      chk("stall_valid", o_rsp_valid, 1);
      chk("stall_rdata", o_rsp_rdata, snap_rd);
      chk("stall_err", o_rsp_err, snap_err);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    req_valid = 1'b0;
    chk("done_req_ready", o_req_ready, 0);
    chk("done_valid", o_rsp_valid, 1);
    if (sb.size() == 0) begin
      chk("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      chk("rsp_rdata", o_rsp_rdata, e[31:0]);
      chk("rsp_err", o_rsp_err, e[32]);
    end
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("idle_req_ready", o_req_ready, 1);
    chk("idle_valid", o_rsp_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    #12;
    chk("rst_req_ready", o_req_ready, 1);
    chk("rst_valid", o_rsp_valid, 0);
    chk("rst_err", o_rsp_err, 0);
    chk("rst_rdata", o_rsp_rdata, 0);
    @(negedge clk);
    reset = 1'b1;

    // Store then load
    txn(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0);
    // Byte enables: expected 0x11BB33DD
    txn(1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    txn(1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 0);
    txn(1'b0, 32'h20, 32'h0, 4'h0, 1);
    // Errors
    txn(1'b1, 32'h0, 32'h5A5A0001, 4'hF, 0);
    txn(1'b0, 32'h2, 32'h0, 4'h0, 0);
    txn(1'b1, 32'd1024, 32'hFFFFFFFF, 4'hF, 0);
    txn(1'b1, 32'h1, 32'hFFFFFFFF, 4'hF, 0);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0);
    txn(1'b0, 32'h80000010, 32'h0, 4'h0, 0);
    // Empty byte enable and long backpressure
    txn(1'b1, 32'h10, 32'hFFFFFFFF, 4'h0, 0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 5);
    // Last word, partial store
    txn(1'b1, 32'h3FC, 32'h01020304, 4'hF, 0);
    txn(1'b1, 32'h3FC, 32'hEE000000, 4'b1000, 2);
    txn(1'b0, 32'h3FC, 32'h0, 4'h0, 0);

    // Reset during WAIT of a store to 0x30
    txn(1'b1, 32'h30, 32'hCAFEF00D, 4'hF, 0);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h12345678; req_be = 4'hF;
    chk("abort_accept", o_req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("abort_in_wait", o_req_ready, 0);
    #2 reset = 1'b0;
    #1;
    chk("abort_req_ready", o_req_ready, 1);
    chk("abort_valid", o_rsp_valid, 0);
    chk("abort_err", o_rsp_err, 0);
    chk("abort_rdata", o_rsp_rdata, 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("abort_no_rsp", o_rsp_valid, 0);
      @(negedge clk);
    end
    txn(1'b0, 32'h30, 32'h0, 4'h0, 0);

    // Zero-wait-state instance, 16 words
    sel = 1'b1;
    @(negedge clk);
    txn(1'b1, 32'h4, 32'h0BADF00D, 4'hF, 0);
    txn(1'b0, 32'h4, 32'h0, 4'h0, 0);
    txn(1'b1, 32'h40, 32'h55555555, 4'hF, 0);
    txn(1'b1, 32'h3C, 32'h00C0FFEE, 4'b0011, 0);
    txn(1'b1, 32'h3C, 32'h77000000, 4'b1100, 0);
    txn(1'b0, 32'h3C, 32'h0, 4'h0, 3);
    txn(1'b0, 32'h4, 32'h0, 4'h0, 2);

    chk("sb_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
